// File: rtl/debounce_pkg.sv
// Shared defaults and counter-width helpers for the debounced button array.
package debounce_pkg;

    localparam int unsigned DEF_STABLE_CYC = 32'd2_000_000;
    localparam int unsigned DEF_LONG_CYC   = 32'd50_000_000;

    // Width of the stable counter; never narrower than one bit.
    function automatic int unsigned stable_cnt_width(input int unsigned stable_cyc);
        if (stable_cyc < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(stable_cyc);
        end
    endfunction

    // Width of the hold counter; a disabled long-press still yields a legal width.
    function automatic int unsigned hold_cnt_width(input int unsigned long_cyc);
        if (long_cyc < 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(long_cyc + 32'd1);
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter with edge pulses,
// and an optional one-shot long-press detector.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
    parameter int unsigned LONG_CYC   = DEF_LONG_CYC
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_press_o
);

    localparam int unsigned SW = stable_cnt_width(STABLE_CYC);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 32'd1);

    logic          s1_q, s2_q;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Synchronizer, debounce counter and edge-pulse registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A disagreeing sample advances the count; any agreeing sample restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == STABLE_LAST) begin
                level_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + SW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

    if (LONG_CYC > 32'd0) begin : g_long
        localparam int unsigned HW = hold_cnt_width(LONG_CYC);
        localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 32'd1);

        logic [HW-1:0] hold_q, hold_d;
        logic          done_q, done_d;
        logic          lp_q, lp_d;

        // Hold counter, one-shot flag and long-press pulse registers.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                hold_q <= '0;
                done_q <= 1'b0;
                lp_q   <= 1'b0;
            end else begin
                hold_q <= hold_d;
                done_q <= done_d;
                lp_q   <= lp_d;
            end
        end

        // Counting stops once the pulse has fired, so it cannot wrap or repeat.
        always_comb begin
            hold_d = hold_q;
            done_d = done_q;
            lp_d   = 1'b0;
            if (!level_q || rise_d) begin
                hold_d = '0;
                done_d = 1'b0;
            end else if (!done_q) begin
                if (hold_q == HOLD_LAST) begin
                    lp_d   = 1'b1;
                    done_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end else begin
                hold_d = hold_q;
            end
        end

        assign long_press_o = lp_q;
    end else begin : g_no_long
        assign long_press_o = 1'b0;
    end

endmodule

// File: rtl/debounce_array.sv
// Array of independent debounced button channels sharing only clock and reset.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH       = 32'd4,
    parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
    parameter int unsigned LONG_CYC   = DEF_LONG_CYC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYC (STABLE_CYC),
            .LONG_CYC   (LONG_CYC)
        ) u_ch (
            .clk_i        (clk),
            .reset_i      (reset),
            .btn_i        (btn_in[g]),
            .level_o      (level[g]),
            .rise_o       (rise[g]),
            .fall_o       (fall[g]),
            .long_press_o (long_press[g])
        );
    end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array with N_CH=4, STABLE_CYC=8, LONG_CYC=32.
module tb_debounce_array;

    logic       clk;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] long_press;

    int total;
    int bad;

    debounce_array #(
        .N_CH       (32'd4),
        .STABLE_CYC (32'd8),
        .LONG_CYC   (32'd32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        btn_in = 4'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        btn_in = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if ({level, rise, fall, long_press} !== 16'h0000) begin
                bad++;
                $display("FAIL reset_outputs step=%0d got=%h exp=0000", i, {level, rise, fall, long_press});
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            total++;
            if (rise !== ((i == 10) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL reset_rise step=%0d got=%b exp=%b", i, rise, (i == 10) ? 4'hF : 4'h0);
            end
            total++;
            if (level !== ((i >= 10) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL reset_level step=%0d got=%b exp=%b", i, level, (i >= 10) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_clean_press();
        apply_reset();
        btn_in = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            step();
            total++;
            if (rise !== ((i == 10) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL clean_rise step=%0d got=%b exp=%b", i, rise, (i == 10) ? 4'b0001 : 4'b0000);
            end
            total++;
            if (fall !== 4'b0000) begin
                bad++;
                $display("FAIL clean_fall step=%0d got=%b exp=0000", i, fall);
            end
            total++;
            if (level !== ((i >= 10) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL clean_level step=%0d got=%b exp=%b", i, level, (i >= 10) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int seg = 0; seg < 10; seg++) begin
            btn_in = (seg % 2 == 0) ? 4'b0010 : 4'b0000;
            for (int j = 0; j < 3; j++) begin
                step();
                total++;
                if ({level, rise, fall} !== 12'h000) begin
                    bad++;
                    $display("FAIL bounce_quiet seg=%0d got=%h exp=000", seg, {level, rise, fall});
                end
            end
        end
        btn_in = 4'b0010;
        for (int i = 1; i <= 14; i++) begin
            step();
            total++;
            if (rise !== ((i == 10) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL bounce_rise step=%0d got=%b exp=%b", i, rise, (i == 10) ? 4'b0010 : 4'b0000);
            end
            total++;
            if (fall !== 4'b0000) begin
                bad++;
                $display("FAIL bounce_fall step=%0d got=%b exp=0000", i, fall);
            end
        end
    endtask

    task automatic test_long_press();
        apply_reset();
        btn_in = 4'b0100;
        for (int i = 1; i <= 60; i++) begin
            step();
            total++;
            if (long_press !== ((i == 42) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL long_pulse step=%0d got=%b exp=%b", i, long_press, (i == 42) ? 4'b0100 : 4'b0000);
            end
            total++;
            if (rise !== ((i == 10) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL long_rise step=%0d got=%b exp=%b", i, rise, (i == 10) ? 4'b0100 : 4'b0000);
            end
        end
        btn_in = 4'b0000;
        for (int i = 1; i <= 40; i++) begin
            step();
            total++;
            if (fall !== ((i == 10) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL long_fall step=%0d got=%b exp=%b", i, fall, (i == 10) ? 4'b0100 : 4'b0000);
            end
            total++;
            if (long_press !== 4'b0000) begin
                bad++;
                $display("FAIL long_repeat step=%0d got=%b exp=0000", i, long_press);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        btn_in = 4'b1000;
        for (int i = 1; i <= 7; i++) begin
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({level, rise} !== 8'h00) begin
            bad++;
            $display("FAIL midreset_abort got=%h exp=00", {level, rise});
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            total++;
            if (rise !== ((i == 10) ? 4'b1000 : 4'b0000)) begin
                bad++;
                $display("FAIL midreset_rise step=%0d got=%b exp=%b", i, rise, (i == 10) ? 4'b1000 : 4'b0000);
            end
            total++;
            if (level[3] !== (i >= 10)) begin
                bad++;
                $display("FAIL midreset_level step=%0d got=%b exp=%b", i, level[3], (i >= 10));
            end
        end
    endtask

    task automatic test_concurrency();
        apply_reset();
        btn_in = 4'b0010;
        for (int i = 1; i <= 12; i++) begin
            step();
        end
        total++;
        if (level !== 4'b0010) begin
            bad++;
            $display("FAIL conc_setup got=%b exp=0010", level);
        end
        btn_in = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            step();
            total++;
            if (rise !== ((i == 10) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL conc_rise step=%0d got=%b exp=%b", i, rise, (i == 10) ? 4'b0001 : 4'b0000);
            end
            total++;
            if (fall !== ((i == 10) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL conc_fall step=%0d got=%b exp=%b", i, fall, (i == 10) ? 4'b0010 : 4'b0000);
            end
        end
        total++;
        if (level !== 4'b0001) begin
            bad++;
            $display("FAIL conc_level got=%b exp=0001", level);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        btn_in = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_reset_mid();
        test_concurrency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_array.md
DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 SHALL have parameter STABLE_CYC, default 2_000_000: consecutive stable cycles needed to accept a level change, range 2..2^24.
REQ-003 SHALL have parameter LONG_CYC, default 50_000_000: high-hold cycles before a long-press pulse; 0 disables long-press.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port btn_in, input, N_CH bits: raw asynchronous button inputs, active-high.
REQ-007 SHALL have port level, output, N_CH bits: debounced, registered button state.
REQ-008 SHALL have port rise, output, N_CH bits: one-cycle pulse when level goes 0->1.
REQ-009 SHALL have port fall, output, N_CH bits: one-cycle pulse when level goes 1->0.
REQ-010 SHALL have port long_press, output, N_CH bits: one-cycle pulse, at most once per press.

Function
REQ-011 Each channel SHALL pass btn_in[i] through a 2-flop synchronizer (s1, s2); only s2 feeds the debounce logic.
REQ-012 Each channel SHALL hold a stable counter of width $clog2(STABLE_CYC).
REQ-013 The stable counter SHALL clear in any cycle where s2 == level[i].
REQ-014 Each cycle s2 != level[i] and the counter is below STABLE_CYC-1, the counter SHALL increment by 1.
REQ-015 When s2 != level[i] and the counter == STABLE_CYC-1, on that edge: level[i] <= s2, counter <= 0, rise[i] or fall[i] <= 1.
REQ-016 Latency: a btn_in change first sampled at edge k and held stable SHALL update level at edge k+1+STABLE_CYC; rise/fall assert on that same edge.
REQ-017 Any bounce, i.e. s2 returning to level before the count completes, SHALL restart the count from 0 and produce no pulse.
REQ-018 rise, fall and long_press SHALL each be high for exactly one cycle per event; rise and fall SHALL never be high together on one channel.
REQ-019 Each channel SHALL hold a hold counter (width $clog2(LONG_CYC+1)) and a long_done flag.
REQ-020 The hold counter and long_done SHALL clear whenever level[i] == 0 or rise[i] fires.
REQ-021 While level[i] == 1 and !long_done, the hold counter SHALL increment by 1 each cycle.
REQ-022 When the hold counter reaches LONG_CYC-1: long_press[i] pulses, long_done <= 1, and the counter stops.
REQ-023 Long-press SHALL occur LONG_CYC cycles after the rise edge.
REQ-024 If LONG_CYC == 0, long_press SHALL be constant 0 and hold logic SHALL be removed.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-026 Counters SHALL never wrap; saturation is structurally impossible per REQ-014/REQ-022.

Reset
REQ-027 On reset: s1, s2, level, rise, fall, long_press, all counters and long_done SHALL be 0 on the next edge.
REQ-028 Reset mid-count SHALL abort the count with no pulse.
REQ-029 If btn_in is high across reset release, the channel SHALL debounce from scratch and rise after the full latency.

Structure
REQ-030 Package debounce_pkg SHALL hold the default STABLE_CYC and LONG_CYC constants and the counter-width functions.
REQ-031 Sub-module debounce_channel SHALL implement one channel (REQ-011..REQ-024).
REQ-032 debounce_array SHALL instantiate N_CH copies of debounce_channel in a generate loop, with no cross-channel logic.

Verification (N_CH=4, STABLE_CYC=8, LONG_CYC=32)
REQ-033 Reset: set btn_in=4'hF during reset -> all outputs 0 while reset is high; rise=4'hF exactly 10 edges after reset release.
REQ-034 Clean press: ch0 high at edge k, held 20 cycles -> rise[0] single pulse at edge k+9; level[0]=1; no fall.
REQ-035 Bounce: ch1 toggles every 3 cycles for 30 cycles, then held high -> no pulses during toggling; exactly one rise[1] at 9 edges after the final transition.
REQ-036 Long press: ch2 held 60 cycles -> long_press[2] once, 32 cycles after rise[2]; then release -> fall[2] 9 edges after the release; no second long_press.
REQ-037 Reset mid-count: ch3 high, reset asserted when the counter is 5 -> no rise; level[3]=0; after release, rise[3] at edge release+10.
REQ-038 Concurrency: ch0 press and ch1 release on the same edge -> rise[0] and fall[1] in the same cycle.
